// File: rtl/mips_instruction_op_func_encode_if.sv
// mips_instruction_op_func_encode_if
//   Bundles the request and result handshakes of the MIPS opFunc encoder.
//   Request side : inValid/inReady, opFunc[6:0], rs, rt, rd, shamt (5 bits),
//                  imm[31:0], wide
//   Result side  : outValid/outReady, word[31:0], last
//   master : the producer of requests and consumer of words (e.g. a loader)
//   slave  : the encoder itself
interface mips_instruction_op_func_encode_if;
  logic        inValid;
  logic        inReady;
  logic [6:0]  opFunc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm;
  logic        wide;
  logic        outValid;
  logic        outReady;
  logic [31:0] word;
  logic        last;

  modport master (
    output inValid, opFunc, rs, rt, rd, shamt, imm, wide, outReady,
    input  inReady, outValid, word, last
  );

  modport slave (
    input  inValid, opFunc, rs, rt, rd, shamt, imm, wide, outReady,
    output inReady, outValid, word, last
  );
endinterface

// File: rtl/mips_instruction_op_func_encode.sv
// mips_instruction_op_func_encode
//   Turns an opFunc code plus register/immediate fields into a 32-bit MIPS
//   instruction word. One request is accepted per inValid&&inReady and its
//   word(s) are presented registered on the result handshake.
//
// Ports:
//   clock  : rising-edge clock
//   resetN : synchronous active-low reset
//   bus    : request/result handshake bundle (slave modport)
//
// Configuration macro: MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
//   Defined   : a 'wide' request loads a full 32-bit immediate into rt and
//               may expand into a lui/ori pair (FIRST state + pending word).
//   Undefined : 'wide' is ignored; every request yields one word, last = 1.
module mips_instruction_op_func_encode (
  input  logic clock,
  input  logic resetN,
  mips_instruction_op_func_encode_if.slave bus
);

  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_ORI = 6'b001101;

`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FIRST = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
`endif

  // Encodes a non-wide request: R-format, J-format (j/jal) or I-format.
  function automatic logic [31:0] encode_normal(
    input logic [6:0]  op_func,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [25:0] imm
  );
    logic [31:0] w;
    if (op_func[6]) begin
      w = {6'b000000, rs, rt, rd, shamt, op_func[5:0]};
    end else if (op_func[5:1] == 5'b00001) begin
      w = {op_func[5:0], imm[25:0]};
    end else begin
      w = {op_func[5:0], rs, rt, imm[15:0]};
    end
    return w;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] word_r;
  logic [31:0] word_nxt_s;
  logic        last_r;
  logic        last_nxt_s;
  logic [31:0] new_word_s;
  logic        new_last_s;
  logic        out_valid_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        take_s;

`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
  logic [31:0] pend_r;
  logic [31:0] pend_nxt_s;
  logic [31:0] new_pend_s;
  logic        new_pair_s;
  logic [15:0] imm_hi_s;
  logic [15:0] imm_lo_s;

  assign imm_hi_s = bus.imm[31:16];
  assign imm_lo_s = bus.imm[15:0];
`else
  // Fields that only the wide path would consume.
  logic unused_s;
  assign unused_s = ^{bus.wide, bus.imm[31:26]};
`endif

  assign out_valid_s = (state_r != IDLE);
  assign take_s      = out_valid_s && bus.outReady;

  // Ready depends only on reset, state and outReady, never on inValid.
`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
  assign in_ready_s = resetN && (state_r != FIRST) && (!out_valid_s || bus.outReady);
`else
  assign in_ready_s = resetN && (!out_valid_s || bus.outReady);
`endif
  assign accept_s = bus.inValid && in_ready_s;

  // Word(s) the current request would load if accepted this cycle.
  always_comb begin
    new_word_s = encode_normal(bus.opFunc, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm[25:0]);
    new_last_s = 1'b1;
`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
    new_pair_s = 1'b0;
    new_pend_s = 32'h0000_0000;
    if (bus.wide) begin
      if (imm_hi_s == 16'h0000) begin
        // Upper half empty (including imm == 0): ori from $0 alone.
        new_word_s = {OP_ORI, 5'd0, bus.rt, imm_lo_s};
      end else if (imm_lo_s == 16'h0000) begin
        new_word_s = {OP_LUI, 5'd0, bus.rt, imm_hi_s};
      end else begin
        new_word_s = {OP_LUI, 5'd0, bus.rt, imm_hi_s};
        new_last_s = 1'b0;
        new_pair_s = 1'b1;
        new_pend_s = {OP_ORI, bus.rt, bus.rt, imm_lo_s};
      end
    end else begin
      new_pair_s = 1'b0;
    end
`endif
  end

  // Next-state and output-register update for the output FSM.
  always_comb begin
    state_nxt_s = state_r;
    word_nxt_s  = word_r;
    last_nxt_s  = last_r;
`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
    pend_nxt_s  = pend_r;
`endif
    case (state_r)
      IDLE, HOLD: begin
        if (accept_s) begin
          // A take in HOLD coincides with this load, so no bubble.
          word_nxt_s  = new_word_s;
          last_nxt_s  = new_last_s;
`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
          pend_nxt_s  = new_pend_s;
          state_nxt_s = new_pair_s ? FIRST : HOLD;
`else
          state_nxt_s = HOLD;
`endif
        end else if (take_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
      FIRST: begin
        if (take_s) begin
          state_nxt_s = HOLD;
          word_nxt_s  = pend_r;
          last_nxt_s  = 1'b1;
          pend_nxt_s  = 32'h0000_0000;
        end else begin
          state_nxt_s = FIRST;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_r <= IDLE;
      word_r  <= 32'h0000_0000;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      word_r  <= word_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

`ifdef MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN
  // Pending ori of a lui/ori pair; reset drops any half-emitted pair.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      pend_r <= 32'h0000_0000;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end
`endif

  assign bus.inReady  = in_ready_s;
  assign bus.outValid = out_valid_s;
  assign bus.word     = word_r;
  assign bus.last     = last_r;

endmodule

// File: doc/mips_instruction_op_func_encode.md
# mips_instruction_op_func_encode

Sequential instruction encoder that turns an opFunc code plus register/immediate fields back into 32-bit MIPS instruction words, acting as the encoder counterpart to instruction categorization and decode. It feeds the test-program loader and the micro-sequencer. Requests and results each use a valid/ready handshake. An optional expansion path emits the two-word `lui`/`ori` sequence for a full 32-bit immediate load.

## Interface
Parameters: none.

Ports:
- `clock`  input  1  single clock; all state updates on rising edge.
- `resetN`  input  1  reset, synchronous, active-low.
- `inValid`  input  1  request present.
- `inReady`  output  1  request accepted this cycle when `inValid && inReady`.
- `opFunc`  input  7  `[6]` is the source: 1 = Func (R-format, op field 0), 0 = Op; `[5:0]` is the func or op code.
- `rs`, `rt`, `rd`, `shamt`  input  5 each  register and shift fields.
- `imm`  input  32  immediate: `[15:0]` for I-format, `[25:0]` for J-format, all 32 bits for wide loads.
- `wide`  input  1  request is a 32-bit immediate load into `rt`; `opFunc` is ignored.
- `outValid`  output  1  `word` is valid.
- `outReady`  input  1  consumer takes `word` when `outValid && outReady`.
- `word`  output  32  encoded instruction.
- `last`  output  1  `word` is the final word of its request.

## Operation
Encoding rules:
- Func source: `{6'b0, rs, rt, rd, shamt, opFunc[5:0]}`.
- Op source with `opFunc[5:1] == 5'b00001` (j/jal): `{opFunc[5:0], imm[25:0]}`.
- Any other Op source: `{opFunc[5:0], rs, rt, imm[15:0]}`.

Wide expansion:
- Both halves non-zero: emit `lui rt, imm[31:16]` (`{6'b001111, 5'd0, rt, imm[31:16]}`), then `ori rt, rt, imm[15:0]` (`{6'b001101, rt, rt, imm[15:0]}`).
- `imm[15:0] == 0`: emit the `lui` only, with `last = 1`.
- `imm[31:16] == 0`: emit `ori rt, $0, imm[15:0]` only, with `last = 1`. This includes `imm == 0`, which gives `ori rt,$0,0`.

State machine:
- `IDLE`: output register empty.
- `HOLD`: output register holds a word with `last = 1`.
- `FIRST`: output holds the `lui` of a two-word pair; the `ori` is pending in an internal register.
- Transitions:
  - `IDLE` goes to `HOLD` or `FIRST` on accept.
  - `HOLD` goes to `IDLE` on output take with no simultaneous accept.
  - `HOLD` reloads to `HOLD` or `FIRST` on take plus simultaneous accept.
  - `FIRST` goes to `HOLD` on take; the `ori` loads into the output.

Handshake:
- `inReady = resetN && state != FIRST && (!outValid || outReady)`. It is combinational, with no path from `inValid` to `inReady`.
- `word` and `last` stay stable while `outValid && !outReady`.
- Only `word`, `last`, the state and the pending register are registered. Input fields are sampled once, at accept.

## Timing
- Reset (`resetN` low at an edge):
  - State goes to `IDLE`; `outValid = 0`, `word = 32'h0`, `last = 0`; the pending register is cleared.
  - `inReady` is 0 while `resetN` is low.
  - Reset in `FIRST` discards the pending `ori`; no partial pair resumes.
- Latency: accept at edge N gives `outValid = 1` with the word from edge N (visible in cycle N+1).
- Throughput:
  - One word per cycle for single-word requests under continuous `outReady`.
  - A two-word request occupies two output cycles, with `inReady = 0` during the `lui` cycle.
- Simultaneous take and accept: the new word replaces the old one at the same edge, with no bubble.

## Configuration
`MIPS_INSTRUCTION_OPFUNC_ENCODE_WIDE_EN`:
- Defined: wide expansion and the `FIRST` state are built as described.
- Undefined:
  - The `wide` port remains but is ignored, and the request is encoded by the normal rules.
  - `FIRST` and the pending register are not built.
  - `last` is constant 1 whenever `outValid`.

## Test plan
- Func request, `opFunc = {1,6'b100000}`, `rs = 1`, `rt = 2`, `rd = 3`, `shamt = 0` -> `word = 32'h00221820`, `last = 1`, one cycle after accept.
- Op request, `opFunc = {0,6'b001001}`, `rs = 1`, `rt = 2`, `imm = 32'h0000FFFF` -> `32'h2422FFFF`. Then `opFunc = {0,6'b000010}`, `imm = 32'h00100000` -> `32'h08100000`.
- Wide (macro on), `rt = 8`, `imm = 32'h12345678` -> `32'h3C081234` (`last = 0`), then `32'h35085678` (`last = 1`). `inReady = 0` during the first word.
- Wide edge cases:
  - `imm = 32'hABCD0000` -> single `32'h3C08ABCD`.
  - `imm = 32'h00000042` -> single `32'h34080042`.
  - Both have `last = 1`.
- Backpressure: hold `outReady = 0` for 3 cycles with `inValid = 1` -> `word` stable, `inReady = 0`. On release, back-to-back words with no bubble.
- Reset in `FIRST` (after `32'h3C081234` is shown) -> next cycle `outValid = 0`, `word = 0`, state `IDLE`, no `ori` emitted. A fresh request then encodes normally.
